// File: rtl/my_seq_multiplier.sv
// Unsigned WIDTHxWIDTH shift-add multiplier: one partial-product step per clock,
// fixed WIDTH-cycle latency, start/busy/done handshake for the ALU sequencer.
module my_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     first,
    input  logic [WIDTH-1:0]     second,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH:0]   acc_reg;
    logic [CW-1:0]      count_reg;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum_next;
    logic [2*WIDTH:0]   acc_next;

    // Partial product: multiplicand gated by the current multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // Add into the upper WIDTH+1 bits (top bit is always 0 here, so the carry
    // lands in it), then shift the whole accumulator right by one.
    always_comb begin
        sum_next = acc_reg[2*WIDTH:WIDTH] + {1'b0, addend};
        acc_next = {1'b0, sum_next, acc_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_reg  <= first;
                        mplier_reg <= second;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        busy       <= 1'b1;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    acc_reg    <= acc_next;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == CW'(WIDTH - 1)) begin
                        result    <= acc_next[2*WIDTH-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_my_seq_multiplier.sv
// Directed + randomized bench for my_seq_multiplier; products and cycle timing
// come from plain 64-bit arithmetic and a cycle counter.
module tb_my_seq_multiplier;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   first;
    logic [W-1:0]   second;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;

    int             vectors = 0;
    int             miscompares = 0;
    int             cyc = 0;
    int             last_done = 0;
    bit             track = 1'b0;
    logic [63:0]    last_result = '0;

    my_seq_multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .first  (first),
        .second (second),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One full operation: accept, WIDTH calc cycles, DONE, one cycle back in IDLE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input bit scramble, input bit start_in_done);
        logic [63:0] exp;
        exp = {32'b0, a} * {32'b0, b};
        first = a;
        second = b;
        start = 1'b1;
        tick();
        chk("accept_flags", {62'b0, busy, done}, 64'b10);
        if (!hold) start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (scramble && k < W) begin
                start = k[0];
                first = 32'hA2341000;
                second = 32'hCAB11318;
            end
            tick();
            if (k < W) begin
                chk("calc_flags", {62'b0, busy, done}, 64'b10);
                chk("result_hold", result, last_result);
            end else begin
                chk("done_flags", {62'b0, busy, done}, 64'b01);
                chk("product", result, exp);
                if (track) chk("done_spacing", 64'(cyc - last_done), 64'd34);
                last_done = cyc;
                track = hold;
            end
        end
        start = hold | start_in_done;
        tick();
        chk("post_done_flags", {62'b0, busy, done}, 64'b00);
        chk("post_done_result", result, exp);
        last_result = exp;
        start = hold;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset held with start asserted: nothing accepted.
        reset = 1'b1;
        start = 1'b1;
        first = 32'd7;
        second = 32'd9;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_flags", {62'b0, busy, done}, 64'b00);
            chk("reset_result", result, 64'd0);
        end
        reset = 1'b0;

        // Small operands, accepted on the first edge after reset.
        do_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("small_held", result, 64'h000000000000000F);

        // Large operands back-to-back, start raised in the DONE cycle.
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        do_op(32'hFFFFFFFF, 32'h10000001, 1'b0, 1'b0, 1'b0);

        // Inputs toggled during CALC must not disturb the operation.
        do_op(32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b1);
        tick();
        chk("no_extra_done", {62'b0, busy, done}, 64'b00);

        // Reset at the 10th CALC edge abandons the operation.
        first = $urandom;
        second = $urandom;
        start = 1'b1;
        tick();
        chk("midreset_accept", {62'b0, busy, done}, 64'b10);
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        chk("midreset_flags", {62'b0, busy, done}, 64'b00);
        chk("midreset_result", result, 64'd0);
        reset = 1'b0;
        last_result = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("midreset_quiet", {62'b0, busy, done}, 64'b00);
        end
        do_op(32'hBEF44587, 32'd1, 1'b0, 1'b0, 1'b0);

        // Continuous start across three operations: done spaced 34 cycles.
        track = 1'b0;
        do_op($urandom, $urandom, 1'b1, 1'b0, 1'b0);
        do_op($urandom, $urandom, 1'b1, 1'b0, 1'b0);
        do_op($urandom, $urandom, 1'b0, 1'b0, 1'b0);

        // Randomized operands, including a zero multiplier and multiplicand.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 2) rb = '0;
            if (i == 5) ra = '0;
            do_op(ra, rb, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
